alu_issue_ctrl: RTL and testbench

Sequencing front-end for the 8-bit ALU arithmetic path. It accepts one operation request (opcode plus two operands) through a valid/ready handshake and registers it. It then drives the registered operands and a one-hot decode line `d` into the combined adder stage (ADD/SUB/INC/DEC) for exactly one cycle. Finally it captures the returned `ans` into an output register with status flags and a valid/ready handshake, so the combinational adder sits between two register boundaries.

---
 rtl/alu_defs_pkg.sv | 25 ++
 rtl/op_decode.sv | 17 +
 rtl/alu_issue_ctrl.sv | 116 +++++++++++
 tb/tb_alu_issue_ctrl.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs_pkg.sv
// Shared constants and types for the ALU issue path.
// Opcode map, FSM state encoding and operand width.
package alu_defs;

  localparam int WIDTH = 8;
  localparam int OPW   = 3;

  localparam logic [2:0] OP_ADD = 3'd1;
  localparam logic [2:0] OP_SUB = 3'd2;
  localparam logic [2:0] OP_INC = 3'd3;
  localparam logic [2:0] OP_DEC = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic is_arith(
    input logic [2:0] op
  );
    return (op >= OP_ADD) && (op <= OP_DEC);
  endfunction

endpackage

// File: rtl/op_decode.sv
// One-hot opcode decoder with enable.
// Disabled output is all-zero.
module op_decode #(
  parameter int OPW = 3
) (
  input  logic                en,
  input  logic [OPW-1:0]      sel,
  output logic [2**OPW-1:0]   d
);

  // Single hot bit at position sel while enabled
  always_comb begin
    d = '0;
    if (en) d[sel] = 1'b1;
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/capture sequencer around the combinational adder.
// Registers the request, fires add_d one cycle, captures ans.
module alu_issue_ctrl #(
  parameter int WIDTH = 8,
  parameter int OPW   = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [OPW-1:0]     in_opcode,
  input  logic [WIDTH-1:0]   in_op1,
  input  logic [WIDTH-1:0]   in_op2,
  output logic [WIDTH-1:0]   add_op1,
  output logic [WIDTH-1:0]   add_op2,
  output logic [2**OPW-1:0]  add_d,
  input  logic [WIDTH-1:0]   add_ans,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_result,
  output logic               out_zero,
  output logic               out_neg,
  output logic               out_arith
);

  import alu_defs::*;

  state_t           state_q;
  state_t           state_d;
  logic [OPW-1:0]   opc_q;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [WIDTH-1:0] res_q;
  logic             zero_q;
  logic             neg_q;
  logic             arith_q;
  logic             accept;
  logic             exec;

  assign accept = in_valid & in_ready;
  assign exec   = (state_q == EXEC);

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (1'b1)
      state_q == IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = EXEC;
      end
      state_q == EXEC: begin
        state_d = DONE;
      end
      state_q == DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          in_ready = 1'b1;
          state_d  = in_valid ? EXEC : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request registers, loaded only on acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q <= '0;
      op1_q <= '0;
      op2_q <= '0;
    end else if (accept) begin
      opc_q <= in_opcode;
      op1_q <= in_op1;
      op2_q <= in_op2;
    end
  end

  // Result and flags, captured at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_q   <= '0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
      arith_q <= 1'b0;
    end else if (exec) begin
      res_q   <= add_ans;
      zero_q  <= (add_ans == '0);
      neg_q   <= add_ans[WIDTH-1];
      arith_q <= is_arith(opc_q);
    end
  end

  op_decode #(
    .OPW (OPW)
  ) u_dec (
    .en  (exec),
    .sel (opc_q),
    .d   (add_d)
  );

  assign add_op1    = op1_q;
  assign add_op2    = op2_q;
  assign out_result = res_q;
  assign out_zero   = zero_q;
  assign out_neg    = neg_q;
  assign out_arith  = arith_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases plus random traffic
// against a transaction-level reference model.
module tb_alu_issue_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_opcode;
  logic [7:0] in_op1;
  logic [7:0] in_op2;
  logic [7:0] add_op1;
  logic [7:0] add_op2;
  logic [7:0] add_d;
  logic [7:0] add_ans;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_result;
  logic       out_zero;
  logic       out_neg;
  logic       out_arith;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.WIDTH(8), .OPW(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_opcode  (in_opcode),
    .in_op1     (in_op1),
    .in_op2     (in_op2),
    .add_op1    (add_op1),
    .add_op2    (add_op2),
    .add_d      (add_d),
    .add_ans    (add_ans),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_zero   (out_zero),
    .out_neg    (out_neg),
    .out_arith  (out_arith)
  );

  // Adder stage that sits downstream of the block
  always_comb begin
    add_ans = 8'h00;
    case (add_d)
      8'h02: add_ans = add_op1 + add_op2;
      8'h04: add_ans = add_op1 + (~add_op2 + 8'h01);
      8'h08: add_ans = add_op1 + 8'h01;
      8'h10: add_ans = add_op1 - 8'h01;
      default: add_ans = 8'h00;
    endcase
  end

  task automatic chk(input string name, input logic [7:0] act,
                     input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic bit [7:0] ref_alu(input bit [2:0] op,
                                       input bit [7:0] a,
                                       input bit [7:0] b);
    case (op)
      3'd1: return 8'(a + b);
      3'd2: return 8'(a - b);
      3'd3: return 8'(a + 1);
      3'd4: return 8'(a - 1);
      default: return 8'h00;
    endcase
  endfunction

  // Transaction-level model: a pending execute slot and a result slot
  bit       m_exec;
  bit [2:0] m_op;
  bit [7:0] m_a, m_b;
  bit       m_valid;
  bit [7:0] m_res;
  bit       m_z, m_n, m_ar;
  bit       m_rdy;
  bit       m_acc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_exec = 0; m_op = 0; m_a = 0; m_b = 0;
      m_valid = 0; m_res = 0; m_z = 0; m_n = 0; m_ar = 0;
    end else begin
      m_rdy = !m_exec && (!m_valid || out_ready);
      m_acc = in_valid && m_rdy;
      if (m_exec) begin
        m_res   = ref_alu(m_op, m_a, m_b);
        m_z     = (m_res == 0);
        m_n     = m_res[7];
        m_ar    = (m_op >= 1 && m_op <= 4);
        m_valid = 1;
      end else if (m_valid && out_ready) begin
        m_valid = 0;
      end
      m_exec = m_acc;
      if (m_acc) begin
        m_op = in_opcode;
        m_a  = in_op1;
        m_b  = in_op2;
      end
    end
  end

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (rst_n) begin
      chk("m_in_ready", {7'b0, in_ready},
          {7'b0, !m_exec && (!m_valid || out_ready)});
      chk("m_out_valid", {7'b0, out_valid}, {7'b0, m_valid});
      chk("m_add_d", add_d, m_exec ? 8'(8'h01 << m_op) : 8'h00);
      chk("m_add_op1", add_op1, m_a);
      chk("m_add_op2", add_op2, m_b);
      chk("m_result", out_result, m_res);
      chk("m_flags", {5'b0, out_zero, out_neg, out_arith},
          {5'b0, m_z, m_n, m_ar});
    end
  end

  task automatic set_req(input logic [2:0] op, input logic [7:0] a,
                         input logic [7:0] b);
    in_valid  = 1'b1;
    in_opcode = op;
    in_op1    = a;
    in_op2    = b;
  endtask

  task automatic wait_ready(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 20);
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=0 expected=1", name);
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] op,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] ed, input logic [7:0] er,
                        input logic ez, input logic en,
                        input logic ea);
    @(posedge clk); #1;
    out_ready = 1'b1;
    set_req(op, a, b);
    wait_ready(name);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_d"}, add_d, ed);
    chk({name, "_vld_lo"}, {7'b0, out_valid}, 8'h00);
    @(posedge clk); #1;
    chk({name, "_vld"}, {7'b0, out_valid}, 8'h01);
    chk({name, "_res"}, out_result, er);
    chk({name, "_flags"}, {5'b0, out_zero, out_neg, out_arith},
        {5'b0, ez, en, ea});
    chk({name, "_d_off"}, add_d, 8'h00);
  endtask

  bit [7:0] got[$];
  int       got_cyc[$];
  bit [7:0] b2b_exp[4];

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_opcode = 3'd0;
    in_op1    = 8'h00;
    in_op2    = 8'h00;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h01);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_result", out_result, 8'h00);
    chk("rst_flags", {5'b0, out_zero, out_neg, out_arith}, 8'h00);
    chk("rst_add", add_d | add_op1 | add_op2, 8'h00);
    @(negedge clk);
    rst_n = 1'b1;

    run_op("add", 3'd1, 8'h05, 8'h03, 8'h02, 8'h08, 0, 0, 1);
    run_op("sub", 3'd2, 8'h03, 8'h05, 8'h04, 8'hFE, 0, 1, 1);
    run_op("inc", 3'd3, 8'hFF, 8'h00, 8'h08, 8'h00, 1, 0, 1);
    run_op("dec", 3'd4, 8'h00, 8'h00, 8'h10, 8'hFF, 0, 1, 1);
    run_op("op6", 3'd6, 8'hAA, 8'h11, 8'h40, 8'h00, 1, 0, 0);

    // Backpressure: hold result for 4 cycles, pending request ignored
    @(posedge clk); #1;
    out_ready = 1'b0;
    set_req(3'd1, 8'h10, 8'h20);
    wait_ready("bp_first");
    @(posedge clk); #1;
    set_req(3'd2, 8'h50, 8'h10);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      chk("bp_vld", {7'b0, out_valid}, 8'h01);
      chk("bp_res", out_result, 8'h30);
      chk("bp_rdy", {7'b0, in_ready}, 8'h00);
      chk("bp_op1", add_op1, 8'h10);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    chk("bp_rdy_comb", {7'b0, in_ready}, 8'h01);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_take_op1", add_op1, 8'h50);
    chk("bp_take_d", add_d, 8'h04);
    @(posedge clk); #1;
    chk("bp_res2", out_result, 8'h40);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Back-to-back: four requests with both sides always ready
    b2b_exp = '{8'h02, 8'h04, 8'h0A, 8'h1F};
    begin
      int idx = 0;
      bit acc;
      set_req(3'd1, 8'h01, 8'h01);
      for (int cyc = 0; cyc < 30; cyc++) begin
        @(negedge clk);
        if (out_valid) begin
          got.push_back(out_result);
          got_cyc.push_back(cyc);
        end
        acc = in_ready && in_valid;
        @(posedge clk); #1;
        if (acc) begin
          idx++;
          case (idx)
            1: set_req(3'd1, 8'h02, 8'h02);
            2: set_req(3'd3, 8'h09, 8'h00);
            3: set_req(3'd4, 8'h20, 8'h00);
            default: in_valid = 1'b0;
          endcase
        end
        if (idx >= 4 && got.size() >= 4) break;
      end
      in_valid = 1'b0;
    end
    chk("b2b_count", 8'(got.size()), 8'd4);
    for (int i = 0; i < 4; i++)
      if (i < got.size()) chk("b2b_res", got[i], b2b_exp[i]);
    if (got.size() >= 4)
      chk("b2b_spacing", 8'(got_cyc[3] - got_cyc[0]), 8'd6);

    // Reset while executing
    @(posedge clk); #1;
    set_req(3'd1, 8'h01, 8'h02);
    wait_ready("rst_req");
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rx_d", add_d, 8'h02);
    #1 rst_n = 1'b0;
    #1;
    chk("rx_in_ready", {7'b0, in_ready}, 8'h01);
    chk("rx_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rx_add", add_d | add_op1 | add_op2, 8'h00);
    chk("rx_result", out_result, 8'h00);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rx_post_rdy", {7'b0, in_ready}, 8'h01);
    chk("rx_post_vld", {7'b0, out_valid}, 8'h00);

    // Random traffic, checked by the model every cycle
    for (int i = 0; i < 500; i++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 1) == 1);
      out_ready = ($urandom_range(0, 3) != 0);
      in_opcode = 3'($urandom_range(0, 7));
      in_op1    = 8'($urandom);
      in_op2    = 8'($urandom);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
